taylor_series_engine: RTL

//  Parametrised next-generation four-function Taylor-series engine (sin/cos/sinh/cosh).

---
 rtl/taylor_pkg.sv | 23 ++
 rtl/taylor_sat_accum.sv | 44 ++++
 rtl/taylor_series_engine.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/taylor_pkg.sv
// Shared definitions for the Taylor-series engine: controller states,
// func bit positions and default widths.
package taylor_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_COEF = 3'd1,
    MUL_X1   = 3'd2,
    MUL_X2   = 3'd3,
    ACCUM    = 3'd4,
    DONE     = 3'd5
  } state_t;

  // func[0]: cos-type (series starts at 1.0); func[1]: all terms add
  localparam int FUNC_COS_BIT = 0;
  localparam int FUNC_ADD_BIT = 1;

  localparam int DEF_F_WIDTH      = 8;
  localparam int DEF_I_WIDTH      = 2;
  localparam int DEF_NUM_OF_TERMS = 8;
  localparam int DEF_CNT_WIDTH    = 4;

endpackage

// File: rtl/taylor_sat_accum.sv
// Unsigned accumulator step: acc +/- term with saturation on overflow and
// clamp-to-zero on underflow; sat flags that either limit was hit.
module taylor_sat_accum
  import taylor_pkg::*;
#(
  parameter int F_WIDTH = DEF_F_WIDTH,
  parameter int I_WIDTH = DEF_I_WIDTH
) (
  input  logic [I_WIDTH+F_WIDTH-1:0] acc,
  input  logic [F_WIDTH-1:0]         term,
  input  logic                       sub,
  output logic [I_WIDTH+F_WIDTH-1:0] accNext,
  output logic                       sat
);

  localparam int A_WIDTH = I_WIDTH + F_WIDTH;

  logic [A_WIDTH:0] sumWide;
  logic [A_WIDTH:0] diffWide;

  // Extra MSB is the carry of an add or the borrow of a subtract.
  function automatic logic [A_WIDTH-1:0] satAdd(input logic [A_WIDTH:0] wide);
    return wide[A_WIDTH] ? {A_WIDTH{1'b1}} : wide[A_WIDTH-1:0];
  endfunction

  function automatic logic [A_WIDTH-1:0] clampSub(input logic [A_WIDTH:0] wide);
    return wide[A_WIDTH] ? {A_WIDTH{1'b0}} : wide[A_WIDTH-1:0];
  endfunction

  always_comb begin
    sumWide  = {1'b0, acc} + {{(I_WIDTH+1){1'b0}}, term};
    diffWide = {1'b0, acc} - {{(I_WIDTH+1){1'b0}}, term};
    accNext  = '0;
    sat      = 1'b0;
    if (sub) begin
      accNext = clampSub(diffWide);
      sat     = diffWide[A_WIDTH];
    end else begin
      accNext = satAdd(sumWide);
      sat     = sumWide[A_WIDTH];
    end
  end

endmodule

// File: rtl/taylor_series_engine.sv
// Iterative sin/cos/sinh/cosh engine: each iteration scales the previous term
// by a ROM coefficient and x^2, then adds or subtracts it into a saturating accumulator.
module taylor_series_engine
  import taylor_pkg::*;
#(
  parameter int F_WIDTH      = DEF_F_WIDTH,
  parameter int I_WIDTH      = DEF_I_WIDTH,
  parameter int NUM_OF_TERMS = DEF_NUM_OF_TERMS,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int EARLY_EXIT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           func,
  input  logic [F_WIDTH-1:0]   x,
  input  logic [F_WIDTH-1:0]   tableData,
  output logic [CNT_WIDTH-1:0] addr,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  output logic [CNT_WIDTH-1:0] termCount,
  output logic [I_WIDTH-1:0]   resultIPart,
  output logic [F_WIDTH-1:0]   resultFPart
);

  localparam int A_WIDTH = I_WIDTH + F_WIDTH;
  localparam logic [A_WIDTH-1:0] ONE_FIXED = A_WIDTH'(1) << F_WIDTH;

  state_t                 state;
  state_t                 stateNext;
  logic [F_WIDTH-1:0]     xReg;
  logic [F_WIDTH-1:0]     term;
  logic [A_WIDTH-1:0]     acc;
  logic [A_WIDTH-1:0]     accNext;
  logic [CNT_WIDTH-1:0]   counter;
  logic [CNT_WIDTH-1:0]   termCnt;
  logic                   subMode;
  logic                   allAdd;
  logic                   ovfReg;
  logic                   accSat;
  logic                   lastTerm;
  logic [F_WIDTH-1:0]     mulOperand;
  logic [2*F_WIDTH-1:0]   product;
  logic [F_WIDTH-1:0]     mulHi;

  // Truncating fixed-point multiply: keep the upper half of the product.
  function automatic logic [F_WIDTH-1:0] hiProduct(input logic [2*F_WIDTH-1:0] p);
    return p[2*F_WIDTH-1:F_WIDTH];
  endfunction

  // One multiplier shared by the coefficient and both x passes.
  assign mulOperand = (state == MUL_COEF) ? tableData : xReg;
  assign product    = term * mulOperand;
  assign mulHi      = hiProduct(product);

  assign lastTerm = (counter >= CNT_WIDTH'(NUM_OF_TERMS)) ||
                    ((EARLY_EXIT != 0) && (term == '0));

  taylor_sat_accum #(
    .F_WIDTH (F_WIDTH),
    .I_WIDTH (I_WIDTH)
  ) uSatAccum (
    .acc     (acc),
    .term    (term),
    .sub     (subMode),
    .accNext (accNext),
    .sat     (accSat)
  );

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (start) stateNext = MUL_COEF;
      MUL_COEF: stateNext = MUL_X1;
      MUL_X1:   stateNext = MUL_X2;
      MUL_X2:   stateNext = ACCUM;
      ACCUM:    stateNext = lastTerm ? DONE : MUL_COEF;
      DONE:     stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xReg    <= '0;
      term    <= '0;
      acc     <= '0;
      counter <= '0;
      termCnt <= '0;
      subMode <= 1'b0;
      allAdd  <= 1'b0;
      ovfReg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            xReg    <= x;
            counter <= CNT_WIDTH'(1);
            termCnt <= CNT_WIDTH'(1);
            subMode <= 1'b0;
            allAdd  <= func[FUNC_ADD_BIT];
            ovfReg  <= 1'b0;
            if (func[FUNC_COS_BIT]) begin
              term <= '1;
              acc  <= ONE_FIXED;
            end else begin
              term <= x;
              acc  <= {{I_WIDTH{1'b0}}, x};
            end
          end
        end
        MUL_COEF: begin
          term <= mulHi;
          if (!allAdd) subMode <= ~subMode;
        end
        MUL_X1: term <= mulHi;
        MUL_X2: begin
          term    <= mulHi;
          counter <= counter + CNT_WIDTH'(1);
        end
        ACCUM: begin
          acc     <= accNext;
          termCnt <= termCnt + CNT_WIDTH'(1);
          if (accSat) ovfReg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign addr        = counter;
  assign ovf         = ovfReg;
  assign termCount   = termCnt;
  assign resultIPart = acc[A_WIDTH-1:F_WIDTH];
  assign resultFPart = acc[F_WIDTH-1:0];

endmodule
